// File: rtl/line_clear_ctrl_if.sv
// Board-RAM and control bundle shared by the line-clear controller and its environment.
// master = the controller (owns the RAM bus while busy), slave = requester plus RAM.
interface line_clear_ctrl_if #(
  parameter int DATA_W = 6
);
  logic              start;
  logic              busy;
  logic              done;
  logic [4:0]        lines_cleared;
  logic [7:0]        ram_addr;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    input  start,
    input  ram_rdata,
    output busy,
    output done,
    output lines_cleared,
    output ram_addr,
    output ram_wren,
    output ram_wdata
  );

  modport slave (
    output start,
    output ram_rdata,
    input  busy,
    input  done,
    input  lines_cleared,
    input  ram_addr,
    input  ram_wren,
    input  ram_wdata
  );
endinterface

// File: rtl/line_clear_ctrl.sv
// Post-commit line clearer: scans the board bottom-up, removes full rows by shifting
// everything above down one row, and blanks row 0 after each removal.
module line_clear_ctrl #(
  parameter int COLS   = 10,
  parameter int ROWS   = 20,
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              resetn,
  line_clear_ctrl_if.master bus
);

  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int FULL_W = (ROW_W + COL_W > 8) ? (ROW_W + COL_W) : 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SCAN    = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_ZERO    = 3'd3;
  localparam logic [2:0] S_NEXTROW = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // Each RAM access is a short phase sequence: issue, two read-latency phases, sample,
  // then for writes a setup / strobe / hold triple that keeps addr and data stable.
  localparam logic [2:0] P_ISSUE   = 3'd0;
  localparam logic [2:0] P_WAIT0   = 3'd1;
  localparam logic [2:0] P_WAIT1   = 3'd2;
  localparam logic [2:0] P_SAMPLE  = 3'd3;
  localparam logic [2:0] P_WSETUP  = 3'd4;
  localparam logic [2:0] P_WSTROBE = 3'd5;
  localparam logic [2:0] P_WHOLD   = 3'd6;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  logic [2:0]        state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ROW_W-1:0]  dst_q, dst_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [4:0]        count_q, count_d;
  logic [7:0]        addr_q, addr_d;
  logic              wren_q, wren_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  function automatic logic [7:0] calcAddr(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    logic [FULL_W-1:0] full;
    full = FULL_W'(r) * FULL_W'(COLS) + FULL_W'(c);
    return full[7:0];
  endfunction

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    row_d   = row_q;
    dst_d   = dst_q;
    col_d   = col_q;
    count_d = count_q;
    addr_d  = addr_q;
    wren_d  = wren_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d  = 1'b1;
          count_d = '0;
          row_d   = LAST_ROW;
          col_d   = '0;
          phase_d = P_ISSUE;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        case (phase_q)
          P_ISSUE: begin
            addr_d  = calcAddr(row_q, col_q);
            phase_d = P_WAIT0;
          end
          P_WAIT0: phase_d = P_WAIT1;
          P_WAIT1: phase_d = P_SAMPLE;
          P_SAMPLE: begin
            phase_d = P_ISSUE;
            if (bus.ram_rdata == '0) begin
              state_d = S_NEXTROW;
            end else if (col_q != LAST_COL) begin
              col_d = col_q + 1'b1;
            end else begin
              if (count_q != 5'd31) begin
                count_d = count_q + 1'b1;
              end
              dst_d   = row_q;
              col_d   = '0;
              state_d = S_SHIFT;
            end
          end
          default: phase_d = P_ISSUE;
        endcase
      end

      S_SHIFT: begin
        case (phase_q)
          P_ISSUE: begin
            if (dst_q == '0) begin
              state_d = S_ZERO;
            end else begin
              addr_d  = calcAddr(dst_q - 1'b1, col_q);
              phase_d = P_WAIT0;
            end
          end
          P_WAIT0: phase_d = P_WAIT1;
          P_WAIT1: phase_d = P_SAMPLE;
          P_SAMPLE: begin
            addr_d  = calcAddr(dst_q, col_q);
            wdata_d = bus.ram_rdata;
            phase_d = P_WSETUP;
          end
          P_WSETUP: begin
            wren_d  = 1'b1;
            phase_d = P_WSTROBE;
          end
          P_WSTROBE: begin
            wren_d  = 1'b0;
            phase_d = P_WHOLD;
          end
          P_WHOLD: begin
            phase_d = P_ISSUE;
            if (col_q == LAST_COL) begin
              col_d = '0;
              dst_d = dst_q - 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
          default: phase_d = P_ISSUE;
        endcase
      end

      // After blanking row 0 the same row index is rescanned, since it now holds the row from above.
      S_ZERO: begin
        case (phase_q)
          P_ISSUE: begin
            addr_d  = calcAddr('0, col_q);
            wdata_d = '0;
            phase_d = P_WSETUP;
          end
          P_WSETUP: begin
            wren_d  = 1'b1;
            phase_d = P_WSTROBE;
          end
          P_WSTROBE: begin
            wren_d  = 1'b0;
            phase_d = P_WHOLD;
          end
          P_WHOLD: begin
            phase_d = P_ISSUE;
            if (col_q == LAST_COL) begin
              col_d   = '0;
              state_d = S_SCAN;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
          default: phase_d = P_ISSUE;
        endcase
      end

      S_NEXTROW: begin
        phase_d = P_ISSUE;
        if (row_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          row_d   = row_q - 1'b1;
          col_d   = '0;
          state_d = S_SCAN;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: begin
        busy_d  = 1'b0;
        wren_d  = 1'b0;
        phase_d = P_ISSUE;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      phase_q <= P_ISSUE;
      row_q   <= '0;
      dst_q   <= '0;
      col_q   <= '0;
      count_q <= '0;
      addr_q  <= '0;
      wren_q  <= 1'b0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      row_q   <= row_d;
      dst_q   <= dst_d;
      col_q   <= col_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.lines_cleared = count_q;
  assign bus.ram_addr      = addr_q;
  assign bus.ram_wren      = wren_q;
  assign bus.ram_wdata     = wdata_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl: a behavioural 2-cycle-latency board RAM plus
// hand-computed expected boards and line counts for each scenario.
module tb_line_clear_ctrl;

  localparam int COLS       = 10;
  localparam int ROWS       = 20;
  localparam int DATA_W     = 6;
  localparam int CELLS      = COLS * ROWS;
  localparam int PASS_LIMIT = 40000;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  line_clear_ctrl_if #(.DATA_W(DATA_W)) bus ();

  line_clear_ctrl #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DATA_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] mem       [256];
  logic [DATA_W-1:0] boardInit [CELLS];
  logic [DATA_W-1:0] expBoard  [CELLS];
  logic [DATA_W-1:0] rdStage;
  logic              doLoad = 1'b0;

  // Board RAM: read data appears two cycles after the address changes.
  always @(posedge clk) begin
    if (doLoad) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= boardInit[i];
    end else if (bus.ram_wren) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    rdStage       <= mem[bus.ram_addr];
    bus.ram_rdata <= rdStage;
  end

  int              doneTotal = 0;
  int              wrenCount = 0;
  int              readCount = 0;
  int              nonCol0   = 0;
  int              reads190  = 0;
  logic [ROWS-1:0] rowMask   = '0;
  bit              busyPrev  = 1'b0;
  bit              pendValid = 1'b0;
  bit              pendWrite = 1'b0;
  logic [7:0]      pendAddr  = '0;
  logic [7:0]      lastAddr  = '0;

  task automatic finalizeAccess();
    if (pendValid && !pendWrite) begin
      readCount++;
      rowMask[pendAddr / COLS] = 1'b1;
      if ((pendAddr % COLS) != 0) nonCol0++;
      if (pendAddr == 8'((ROWS - 1) * COLS)) reads190++;
    end
    pendValid = 1'b0;
  endtask

  // Pass monitor: an access is a stable address span; it is a read if wren never rose in it.
  always @(negedge clk) begin
    if (bus.done === 1'b1) doneTotal++;
    if (bus.busy && !busyPrev) begin
      wrenCount = 0; readCount = 0; nonCol0 = 0; reads190 = 0; rowMask = '0;
      pendValid = 1'b0;
      lastAddr  = bus.ram_addr;
    end else if (bus.busy) begin
      if (bus.ram_addr != lastAddr) begin
        finalizeAccess();
        pendAddr  = bus.ram_addr;
        pendValid = 1'b1;
        pendWrite = 1'b0;
      end
      if (bus.ram_wren) begin
        pendWrite = 1'b1;
        wrenCount++;
      end
      lastAddr = bus.ram_addr;
    end else if (busyPrev) begin
      finalizeAccess();
    end
    busyPrev = bus.busy;
  end

  task automatic clearBoards();
    for (int i = 0; i < CELLS; i++) begin
      boardInit[i] = '0;
      expBoard[i]  = '0;
    end
  endtask

  task automatic loadBoard();
    @(negedge clk) doLoad = 1'b1;
    @(negedge clk) doLoad = 1'b0;
  endtask

  task automatic pulseStart();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic waitDone(output bit timedOut);
    timedOut = 1'b1;
    for (int i = 0; i < PASS_LIMIT; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.ram_wren, bus.ram_addr, bus.ram_wdata, bus.lines_cleared} !== 22'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs actual busy=%b done=%b wren=%b addr=%0d wdata=%0d lc=%0d required all 0",
               bus.busy, bus.done, bus.ram_wren, bus.ram_addr, bus.ram_wdata, bus.lines_cleared);
    end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.ram_wren} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL idle_after_reset actual busy/done/wren=%b%b%b required 000", bus.busy, bus.done, bus.ram_wren);
    end
  endtask

  task automatic test_empty_board();
    bit to;
    clearBoards();
    loadBoard();
    pulseStart();
    waitDone(to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL empty_timeout actual no done required done"); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL empty_busy_at_done actual %b required 0", bus.busy); end
    checks++;
    if (bus.lines_cleared !== 5'd0) begin failures++; $display("[TB] FAIL empty_count actual %0d required 0", bus.lines_cleared); end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL empty_done_width actual %b required 0", bus.done); end
    checks++;
    if (wrenCount != 0) begin failures++; $display("[TB] FAIL empty_no_writes actual %0d required 0", wrenCount); end
    checks++;
    if (readCount != ROWS) begin failures++; $display("[TB] FAIL empty_read_count actual %0d required %0d", readCount, ROWS); end
    checks++;
    if (nonCol0 != 0) begin failures++; $display("[TB] FAIL empty_col0_only actual %0d required 0", nonCol0); end
    checks++;
    if (rowMask !== '1) begin failures++; $display("[TB] FAIL empty_rows_read actual %b required all ones", rowMask); end
  endtask

  task automatic test_single_row();
    bit to;
    int bad, first;
    clearBoards();
    for (int x = 0; x < COLS; x++) boardInit[190 + x] = 6'd1;
    boardInit[183] = 6'd5;
    expBoard[193]  = 6'd5;
    loadBoard();
    pulseStart();
    waitDone(to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL single_timeout actual no done required done"); end
    checks++;
    if (bus.lines_cleared !== 5'd1) begin failures++; $display("[TB] FAIL single_count actual %0d required 1", bus.lines_cleared); end
    @(negedge clk);
    bad = 0; first = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== expBoard[i]) begin if (bad == 0) first = i; bad++; end
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL single_board cell %0d actual %0d required %0d (%0d wrong)", first, mem[first], expBoard[first], bad); end
    repeat (20) @(negedge clk);
    checks++;
    if (bus.lines_cleared !== 5'd1) begin failures++; $display("[TB] FAIL single_count_held actual %0d required 1", bus.lines_cleared); end
  endtask

  task automatic test_two_rows();
    bit to;
    int bad, first;
    clearBoards();
    for (int x = 0; x < COLS; x++) begin
      boardInit[180 + x] = 6'd1;
      boardInit[190 + x] = 6'd3;
    end
    boardInit[170] = 6'd2;
    expBoard[190]  = 6'd2;
    loadBoard();
    pulseStart();
    checks++;
    if ({bus.busy, bus.lines_cleared} !== 6'b1_00000) begin
      failures++;
      $display("[TB] FAIL two_start_accept actual busy=%b lc=%0d required busy=1 lc=0", bus.busy, bus.lines_cleared);
    end
    waitDone(to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL two_timeout actual no done required done"); end
    checks++;
    if (bus.lines_cleared !== 5'd2) begin failures++; $display("[TB] FAIL two_count actual %0d required 2", bus.lines_cleared); end
    @(negedge clk);
    bad = 0; first = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== expBoard[i]) begin if (bad == 0) first = i; bad++; end
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL two_board cell %0d actual %0d required %0d (%0d wrong)", first, mem[first], expBoard[first], bad); end
    checks++;
    if (reads190 != 3) begin failures++; $display("[TB] FAIL two_row19_scans actual %0d required 3", reads190); end
  endtask

  task automatic test_mid_row();
    bit to;
    int bad, first;
    clearBoards();
    for (int x = 0; x < COLS; x++) boardInit[100 + x] = 6'd4;
    for (int r = 11; r < ROWS; r++)
      for (int x = 0; x < r - 10; x++) begin
        boardInit[r * COLS + x] = 6'(x + 1);
        expBoard[r * COLS + x]  = 6'(x + 1);
      end
    boardInit[99] = 6'd7;
    expBoard[109] = 6'd7;
    loadBoard();
    pulseStart();
    waitDone(to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL mid_timeout actual no done required done"); end
    checks++;
    if (bus.lines_cleared !== 5'd1) begin failures++; $display("[TB] FAIL mid_count actual %0d required 1", bus.lines_cleared); end
    @(negedge clk);
    bad = 0; first = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== expBoard[i]) begin if (bad == 0) first = i; bad++; end
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL mid_board cell %0d actual %0d required %0d (%0d wrong)", first, mem[first], expBoard[first], bad); end
  endtask

  task automatic test_full_board();
    bit to;
    int bad, first, doneBefore;
    clearBoards();
    for (int i = 0; i < CELLS; i++) boardInit[i] = 6'((i % 63) + 1);
    loadBoard();
    doneBefore = doneTotal;
    pulseStart();
    repeat (200) @(negedge clk);
    pulseStart();
    waitDone(to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL full_timeout actual no done required done"); end
    checks++;
    if (bus.lines_cleared !== 5'd20) begin failures++; $display("[TB] FAIL full_count actual %0d required 20", bus.lines_cleared); end
    repeat (60) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL full_no_restart actual busy=%b required 0", bus.busy); end
    checks++;
    if (doneTotal - doneBefore != 1) begin failures++; $display("[TB] FAIL full_single_done actual %0d required 1", doneTotal - doneBefore); end
    bad = 0; first = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== expBoard[i]) begin if (bad == 0) first = i; bad++; end
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL full_board cell %0d actual %0d required %0d (%0d wrong)", first, mem[first], expBoard[first], bad); end
  endtask

  task automatic test_reset_mid_shift();
    bit to, sawWren;
    int bad, first, doneBefore;
    clearBoards();
    for (int x = 0; x < COLS; x++) begin
      boardInit[190 + x] = 6'd9;
      boardInit[180 + x] = 6'(x);
    end
    loadBoard();
    pulseStart();
    sawWren = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.ram_wren === 1'b1) begin
        sawWren = 1'b1;
        break;
      end
    end
    checks++;
    if (!sawWren) begin failures++; $display("[TB] FAIL rst_shift_wren_seen actual none required wren=1"); end
    doneBefore = doneTotal;
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus.ram_wren, bus.busy} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL rst_async_drop actual wren=%b busy=%b required 00", bus.ram_wren, bus.busy);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (doneTotal != doneBefore) begin failures++; $display("[TB] FAIL rst_no_done actual %0d required 0", doneTotal - doneBefore); end
    resetn = 1'b1;
    clearBoards();
    for (int x = 0; x < COLS; x++) boardInit[190 + x] = 6'd9;
    loadBoard();
    pulseStart();
    waitDone(to);
    checks++;
    if (to) begin failures++; $display("[TB] FAIL rst_rerun_timeout actual no done required done"); end
    checks++;
    if (bus.lines_cleared !== 5'd1) begin failures++; $display("[TB] FAIL rst_rerun_count actual %0d required 1", bus.lines_cleared); end
    @(negedge clk);
    bad = 0; first = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== expBoard[i]) begin if (bad == 0) first = i; bad++; end
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL rst_rerun_board cell %0d actual %0d required %0d (%0d wrong)", first, mem[first], expBoard[first], bad); end
  endtask

  initial begin
    test_reset();
    test_empty_board();
    test_single_row();
    test_two_rows();
    test_mid_row();
    test_full_board();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
